// File: rtl/nibble_selector_fifo.sv
// nibble_selector_fifo: per-lane nibble extract + combine (select/xor/add)
// feeding a DEPTH-entry valid/ready output FIFO.
module nibble_selector_fifo #(
    parameter  int DATA_W = 32,
    parameter  int NIB_W  = 4,
    parameter  int LANES  = 4,
    parameter  int DEPTH  = 2,
    localparam int NIBS   = DATA_W / NIB_W,
    localparam int IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [DATA_W-1:0]      DATA_A,
    input  logic [DATA_W-1:0]      DATA_B,
    input  logic [LANES*IDX_W-1:0] SEL_A,
    input  logic [LANES*IDX_W-1:0] SEL_B,
    input  logic [LANES-1:0]       SEL,
    input  logic [1:0]             MODE,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [LANES*NIB_W-1:0] NIBBLE_OUT,
    output logic [LANES-1:0]       CARRY,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LVL_W-1:0]       LEVEL,
    output logic                   ERR
);

    localparam int RES_W = LANES * NIB_W;
    localparam int ENT_W = RES_W + LANES;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_err;

    logic [RES_W-1:0] w_res;
    logic [LANES-1:0] w_carry;
    logic [LANES-1:0] w_lane_oob;
    logic             w_bad_mode;
    logic             w_beat_err;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IDX_W-1:0] w_ia;
        logic [IDX_W-1:0] w_ib;
        logic             w_oob_a;
        logic             w_oob_b;
        logic [NIB_W-1:0] w_a;
        logic [NIB_W-1:0] w_b;
        logic [NIB_W:0]   w_sum;
        logic [NIB_W-1:0] w_r;
        logic             w_c;

        assign w_ia    = SEL_A[g*IDX_W +: IDX_W];
        assign w_ib    = SEL_B[g*IDX_W +: IDX_W];
        assign w_oob_a = ({1'b0, w_ia} >= (IDX_W+1)'(NIBS));
        assign w_oob_b = ({1'b0, w_ib} >= (IDX_W+1)'(NIBS));
        assign w_a     = w_oob_a ? '0 : NIB_W'(DATA_A >> (w_ia * NIB_W));
        assign w_b     = w_oob_b ? '0 : NIB_W'(DATA_B >> (w_ib * NIB_W));
        assign w_sum   = {1'b0, w_a} + {1'b0, w_b};

        // Combine this lane's two nibbles; reserved mode falls back to select
        always_comb begin
            w_r = SEL[g] ? w_b : w_a;
            w_c = 1'b0;
            unique case (MODE)
                2'b01:   w_r = w_a ^ w_b;
                2'b10:   {w_c, w_r} = w_sum;
                default: w_r = SEL[g] ? w_b : w_a;
            endcase
        end

        assign w_res[g*NIB_W +: NIB_W] = w_r;
        assign w_carry[g]              = w_c;
        assign w_lane_oob[g]           = w_oob_a | w_oob_b;
    end

    assign w_bad_mode = (MODE == 2'b11);
    assign w_beat_err = w_bad_mode | (|w_lane_oob);

    assign IN_READY  = !RESET && (r_level < LVL_W'(DEPTH));
    assign OUT_VALID = (r_level != '0);
    assign w_push    = IN_VALID & IN_READY;
    assign w_pop     = OUT_VALID & OUT_READY;

    assign w_head     = r_mem[r_rd_ptr];
    assign NIBBLE_OUT = w_head[RES_W-1:0];
    assign CARRY      = w_head[ENT_W-1 -: LANES];
    assign LEVEL      = r_level;
    assign ERR        = r_err;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // FIFO storage, pointers, occupancy and sticky error; reset wipes all
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_carry, w_res};
                r_wr_ptr        <= f_next(r_wr_ptr);
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_selector_fifo.sv
// tb_nibble_selector_fifo: scoreboard bench for nibble_selector_fifo,
// plus a 24-bit instance for out-of-range index handling.
module tb_nibble_selector_fifo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] DATA_A, DATA_B;
    logic [11:0] SEL_A, SEL_B;
    logic [3:0]  SEL;
    logic [1:0]  MODE;
    logic        IN_VALID, IN_READY;
    logic [15:0] NIBBLE_OUT;
    logic [3:0]  CARRY;
    logic        OUT_VALID, OUT_READY;
    logic [1:0]  LEVEL;
    logic        ERR;

    logic [23:0] d24_a, d24_b;
    logic [11:0] s24_a, s24_b;
    logic        v24, rdy24, ov24, ordy24, err24;
    logic [15:0] out24;
    logic [3:0]  c24;
    logic [1:0]  lvl24;

    int checks = 0;
    int failures = 0;
    logic [19:0] q[$];

    always #5 CLK = ~CLK;

    nibble_selector_fifo dut (
        .CLK(CLK), .RESET(RESET), .DATA_A(DATA_A), .DATA_B(DATA_B),
        .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL(SEL), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .NIBBLE_OUT(NIBBLE_OUT), .CARRY(CARRY), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .LEVEL(LEVEL), .ERR(ERR)
    );

    nibble_selector_fifo #(.DATA_W(24)) dut24 (
        .CLK(CLK), .RESET(RESET), .DATA_A(d24_a), .DATA_B(d24_b),
        .SEL_A(s24_a), .SEL_B(s24_b), .SEL(SEL), .MODE(MODE),
        .IN_VALID(v24), .IN_READY(rdy24),
        .NIBBLE_OUT(out24), .CARRY(c24), .OUT_VALID(ov24),
        .OUT_READY(ordy24), .LEVEL(lvl24), .ERR(err24)
    );

    function automatic logic [19:0] model(
        input logic [31:0] da, input logic [31:0] db,
        input logic [11:0] sa, input logic [11:0] sb,
        input logic [3:0] sl, input logic [1:0] md);
        logic [15:0] n;
        logic [3:0]  c;
        logic [3:0]  a, b;
        logic [4:0]  s;
        int ia, ib;
        n = '0;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            ia = int'((sa >> (3 * i)) & 12'h7);
            ib = int'((sb >> (3 * i)) & 12'h7);
            a  = 4'(da >> (4 * ia));
            b  = 4'(db >> (4 * ib));
            s  = 5'(a) + 5'(b);
            case (md)
                2'b01: n[4*i +: 4] = a ^ b;
                2'b10: begin
                    n[4*i +: 4] = s[3:0];
                    c[i] = s[4];
                end
                default: n[4*i +: 4] = sl[i] ? b : a;
            endcase
        end
        return {c, n};
    endfunction

    // Scoreboard: pop/compare on each handshake, push on each accepted beat
    always @(negedge CLK) begin
        if (!RESET) begin
            if (OUT_VALID && OUT_READY) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h", {CARRY, NIBBLE_OUT});
                end else begin
                    logic [19:0] e;
                    e = q.pop_front();
                    if ({CARRY, NIBBLE_OUT} !== e) begin
                        failures++;
                        $display("FAIL sb_data got=%h exp=%h",
                                 {CARRY, NIBBLE_OUT}, e);
                    end
                end
            end
            if (IN_VALID && IN_READY) begin
                q.push_back(model(DATA_A, DATA_B, SEL_A, SEL_B, SEL, MODE));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic defaults;
        DATA_A = 32'h76543210;
        DATA_B = 32'hFEDCBA98;
        SEL_A  = {3'd7, 3'd5, 3'd2, 3'd0};
        SEL_B  = {3'd0, 3'd1, 3'd6, 3'd3};
        SEL    = 4'b1010;
        MODE   = 2'b00;
    endtask

    task automatic drain(output bit ok);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || OUT_VALID); i++) tick();
        ok = (q.size() == 0) && !OUT_VALID && (LEVEL == 2'd0);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        defaults();
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        v24 = 1'b0;
        ordy24 = 1'b1;
        d24_a = 24'h543210;
        d24_b = 24'hBA9876;
        s24_a = '0;
        s24_b = '0;
        #3;
        checks++;
        if ({IN_READY, OUT_VALID, LEVEL, ERR, CARRY, NIBBLE_OUT} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {IN_READY, OUT_VALID, LEVEL, ERR, CARRY, NIBBLE_OUT});
        end
        tick();
        tick();
        checks++;
        if (LEVEL !== 2'd0) begin
            failures++;
            $display("FAIL reset_no_accept level=%0d exp=0", LEVEL);
        end
        IN_VALID = 1'b0;
        RESET = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", IN_READY);
        end
    endtask

    task automatic test_modes;
        logic [1:0]  md[3]  = '{2'b00, 2'b01, 2'b10};
        logic [19:0] exp[3] = '{20'h085E0, 20'h0FCCB, 20'h2FE0B};
        defaults();
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MODE = md[i];
            IN_VALID = 1'b1;
            tick();
            IN_VALID = 1'b0;
            checks++;
            if (!OUT_VALID || {CARRY, NIBBLE_OUT} !== exp[i]) begin
                failures++;
                $display("FAIL mode%0d_out valid=%b got=%h exp=%h",
                         i, OUT_VALID, {CARRY, NIBBLE_OUT}, exp[i]);
            end
            tick();
            checks++;
            if (OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL mode%0d_one_cycle valid=%b exp=0", i, OUT_VALID);
            end
        end
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL modes_err got=%b exp=0", ERR);
        end
    endtask

    task automatic test_backpressure;
        logic [19:0] first;
        bit ok;
        defaults();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        SEL = 4'b0000;
        first = model(DATA_A, DATA_B, SEL_A, SEL_B, SEL, MODE);
        tick();
        SEL = 4'b1111;
        tick();
        checks++;
        if (LEVEL !== 2'd2 || IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL bp_full level=%0d ready=%b exp=2/0", LEVEL, IN_READY);
        end
        SEL = 4'b0101;
        tick();
        checks++;
        if (LEVEL !== 2'd2 || {CARRY, NIBBLE_OUT} !== first) begin
            failures++;
            $display("FAIL bp_hold level=%0d head=%h exp=2/%h",
                     LEVEL, {CARRY, NIBBLE_OUT}, first);
        end
        OUT_READY = 1'b1;
        tick();
        checks++;
        if (LEVEL !== 2'd1 || IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL bp_full_pop level=%0d ready=%b exp=1/1",
                     LEVEL, IN_READY);
        end
        tick();
        checks++;
        if (LEVEL !== 2'd1) begin
            failures++;
            $display("FAIL bp_push_pop level=%0d exp=1", LEVEL);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_drain left=%0d level=%0d exp=0", q.size(), LEVEL);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int bad = 0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            DATA_A = $urandom;
            DATA_B = $urandom;
            SEL_A  = 12'($urandom);
            SEL_B  = 12'($urandom);
            SEL    = 4'($urandom);
            MODE   = 2'($urandom_range(0, 2));
            IN_VALID = 1'b1;
            #1;
            if (!IN_READY) bad++;
            tick();
            if (LEVEL > 2'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_throughput stalls=%0d exp=0", bad);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_err;
        bit ok;
        defaults();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        tick();
        tick();
        MODE = 2'b11;
        tick();
        tick();
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL err_unaccepted got=%b exp=0", ERR);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL err_drain left=%0d exp=0", q.size());
        end
        MODE = 2'b11;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (ERR !== 1'b1 || {CARRY, NIBBLE_OUT} !== 20'h085E0) begin
            failures++;
            $display("FAIL err_mode11 err=%b got=%h exp=1/085e0",
                     ERR, {CARRY, NIBBLE_OUT});
        end
        MODE = 2'b01;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (ERR !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", ERR);
        end
    endtask

    task automatic test_oob_index;
        defaults();
        MODE = 2'b00;
        SEL = 4'b0000;
        s24_a = {3'd5, 3'd2, 3'd1, 3'd3};
        v24 = 1'b1;
        tick();
        v24 = 1'b0;
        checks++;
        if (out24 !== 16'h5213 || err24 !== 1'b0 || ov24 !== 1'b1) begin
            failures++;
            $display("FAIL w24_inrange got=%h err=%b exp=5213/0", out24, err24);
        end
        s24_a = {3'd5, 3'd2, 3'd1, 3'd7};
        v24 = 1'b1;
        tick();
        v24 = 1'b0;
        checks++;
        if (out24 !== 16'h5210 || err24 !== 1'b1) begin
            failures++;
            $display("FAIL w24_oob got=%h err=%b exp=5210/1", out24, err24);
        end
        tick();
    endtask

    task automatic test_async_reset;
        defaults();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        tick();
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (LEVEL !== 2'd2) begin
            failures++;
            $display("FAIL ar_fill level=%0d exp=2", LEVEL);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({IN_READY, OUT_VALID, LEVEL, ERR, CARRY, NIBBLE_OUT} !== '0) begin
            failures++;
            $display("FAIL ar_immediate got=%b exp=0",
                     {IN_READY, OUT_VALID, LEVEL, ERR, CARRY, NIBBLE_OUT});
        end
        q.delete();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1;
        tick();
        checks++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL ar_no_accept level=%0d exp=0", LEVEL);
        end
        RESET = 1'b0;
        MODE = 2'b10;
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (!OUT_VALID || {CARRY, NIBBLE_OUT} !== 20'h2FE0B) begin
            failures++;
            $display("FAIL ar_first_beat valid=%b got=%h exp=2fe0b",
                     OUT_VALID, {CARRY, NIBBLE_OUT});
        end
        tick();
        checks++;
        if (OUT_VALID !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL ar_no_stale valid=%b left=%0d exp=0",
                     OUT_VALID, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_err();
        test_oob_index();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
